// File: rtl/mem_if_pkg.sv
// Shared CPU/data-RAM constants and the dump FSM state encoding.
package mem_if_pkg;

  localparam int NB_DATA_DEF = 16;
  localparam int NB_ADDR_DEF = 11;

  typedef logic [1:0] dump_state_t;

  localparam dump_state_t ST_IDLE    = 2'd0;
  localparam dump_state_t ST_READ    = 2'd1;
  localparam dump_state_t ST_PRESENT = 2'd2;
  localparam dump_state_t ST_DONE    = 2'd3;

endpackage

// File: rtl/ram_sp_core.sv
// Synchronous single-port data array, read-first, with separate CPU/dump read registers.
// Optional even-parity column when RAM_PARITY_EN is defined.
module ram_sp_core #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 11
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic [NB_ADDR-1:0] addr_i,
  input  logic               we_i,
  input  logic [NB_DATA-1:0] wdata_i,
  input  logic               cpu_re_i,
  input  logic               dump_re_i,
  output logic [NB_DATA-1:0] cpu_rdata_o,
  output logic [NB_DATA-1:0] dump_rdata_o,
  output logic               par_err_o
);

  localparam int RAM_DEPTH = 2 ** NB_ADDR;

  logic [NB_DATA-1:0] mem_q [RAM_DEPTH];
  logic [NB_DATA-1:0] cpu_rdata_q;
  logic [NB_DATA-1:0] dump_rdata_q;
  logic               par_err_s;

  // Array write; contents deliberately survive reset
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  // Read registers sample the pre-write word, giving read-first behaviour
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cpu_rdata_q  <= '0;
      dump_rdata_q <= '0;
    end else begin
      if (cpu_re_i)  cpu_rdata_q  <= mem_q[addr_i];
      if (dump_re_i) dump_rdata_q <= mem_q[addr_i];
    end
  end

`ifdef RAM_PARITY_EN
  logic par_q [RAM_DEPTH];

  function automatic logic even_parity(input logic [NB_DATA-1:0] data);
    return ^data;
  endfunction

  // Parity column written alongside the data word
  always_ff @(posedge clk_i) begin
    if (we_i) par_q[addr_i] <= even_parity(wdata_i);
  end

  // Any array read (CPU or dump) checks the stored parity
  always_comb begin
    par_err_s = 1'b0;
    if (cpu_re_i || dump_re_i) begin
      par_err_s = (even_parity(mem_q[addr_i]) != par_q[addr_i]);
    end else begin
      par_err_s = 1'b0;
    end
  end
`else
  assign par_err_s = 1'b0;
`endif

  assign cpu_rdata_o  = cpu_rdata_q;
  assign dump_rdata_o = dump_rdata_q;
  assign par_err_o    = par_err_s;

endmodule

// File: rtl/data_memory_responder.sv
// CPU data-RAM responder with a valid/ready memory-dump port; the CPU always wins the port.
// Build option RAM_PARITY_EN enables the parity column and the sticky o_parity_error flag.
module data_memory_responder
  import mem_if_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_ADDR = NB_ADDR_DEF
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [NB_ADDR-1:0] i_ram_addr,
  input  logic [NB_DATA-1:0] i_ram_data,
  input  logic               i_ram_wr_enable,
  input  logic               i_ram_rd_enable,
  output logic [NB_DATA-1:0] o_ram_data,
  input  logic               i_dump_start,
  input  logic [NB_ADDR-1:0] i_dump_base,
  input  logic [NB_ADDR:0]   i_dump_len,
  output logic [NB_DATA-1:0] o_dump_data,
  output logic               o_dump_valid,
  input  logic               i_dump_ready,
  output logic               o_dump_busy,
  output logic               o_dump_done,
  output logic               o_parity_error
);

  dump_state_t        state_q, state_d;
  logic [NB_ADDR-1:0] ptr_q, ptr_d;
  logic [NB_ADDR:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d, busy_q, busy_d, done_q, done_d;
  logic               perr_q, perr_d;
  logic               cpu_active_s, dump_re_s, accept_s, core_perr_s;
  logic [NB_ADDR-1:0] addr_s;

  assign cpu_active_s = i_ram_wr_enable | i_ram_rd_enable;
  assign dump_re_s    = (state_q == ST_READ) && !cpu_active_s;
  assign accept_s     = (state_q == ST_PRESENT) && i_dump_ready;
  assign addr_s       = cpu_active_s ? i_ram_addr : ptr_q;

  ram_sp_core #(
    .NB_DATA (NB_DATA),
    .NB_ADDR (NB_ADDR)
  ) u_ram (
    .clk_i        (i_clock),
    .rst_n_i      (i_reset),
    .addr_i       (addr_s),
    .we_i         (i_ram_wr_enable),
    .wdata_i      (i_ram_data),
    .cpu_re_i     (i_ram_rd_enable),
    .dump_re_i    (dump_re_s),
    .cpu_rdata_o  (o_ram_data),
    .dump_rdata_o (o_dump_data),
    .par_err_o    (core_perr_s)
  );

  // Dump FSM state, pointer and remaining-word counter
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the pointer wraps naturally at the top of the array
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (i_dump_start) begin
          ptr_d   = i_dump_base;
          cnt_d   = i_dump_len;
          state_d = (i_dump_len == '0) ? ST_DONE : ST_READ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (dump_re_s) state_d = ST_PRESENT;
        else           state_d = ST_READ;
      end
      ST_PRESENT: begin
        if (accept_s) begin
          ptr_d   = ptr_q + NB_ADDR'(1);
          cnt_d   = cnt_q - (NB_ADDR+1)'(1);
          state_d = (cnt_q == (NB_ADDR+1)'(1)) ? ST_DONE : ST_READ;
        end else begin
          state_d = ST_PRESENT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the next state so they can be registered
  always_comb begin
    valid_d = (state_d == ST_PRESENT);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    perr_d  = perr_q | core_perr_s;
  end

  // Output registers; parity error is sticky until reset
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  assign o_dump_valid   = valid_q;
  assign o_dump_busy    = busy_q;
  assign o_dump_done    = done_q;
  assign o_parity_error = perr_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench: directed steps plus randomized dumps against an array-based memory model.
module tb_data_memory_responder;

  localparam int DEPTH = 2048;

  logic        clk;
  logic        i_reset;
  logic [10:0] i_ram_addr;
  logic [15:0] i_ram_data;
  logic        i_ram_wr_enable, i_ram_rd_enable;
  logic [15:0] o_ram_data;
  logic        i_dump_start;
  logic [10:0] i_dump_base;
  logic [11:0] i_dump_len;
  logic [15:0] o_dump_data;
  logic        o_dump_valid, i_dump_ready, o_dump_busy, o_dump_done, o_parity_error;

  logic [15:0] model_mem [DEPTH];
  int n_checks = 0;
  int n_fail   = 0;

  data_memory_responder dut (
    .i_clock         (clk),
    .i_reset         (i_reset),
    .i_ram_addr      (i_ram_addr),
    .i_ram_data      (i_ram_data),
    .i_ram_wr_enable (i_ram_wr_enable),
    .i_ram_rd_enable (i_ram_rd_enable),
    .o_ram_data      (o_ram_data),
    .i_dump_start    (i_dump_start),
    .i_dump_base     (i_dump_base),
    .i_dump_len      (i_dump_len),
    .o_dump_data     (o_dump_data),
    .o_dump_valid    (o_dump_valid),
    .i_dump_ready    (i_dump_ready),
    .o_dump_busy     (o_dump_busy),
    .o_dump_done     (o_dump_done),
    .o_parity_error  (o_parity_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input int a, input logic [15:0] d);
    i_ram_addr = 11'(a); i_ram_data = d; i_ram_wr_enable = 1'b1;
    model_mem[a] = d;
    tick();
    i_ram_wr_enable = 1'b0;
  endtask

  task automatic cpu_read_check(input string tag, input int a);
    logic [15:0] e;
    e = model_mem[a];
    i_ram_addr = 11'(a); i_ram_rd_enable = 1'b1;
    tick();
    i_ram_rd_enable = 1'b0;
    check(tag, o_ram_data, e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ram_data"}, o_ram_data, 0);
    check({tag, "_dump_data"}, o_dump_data, 0);
    check({tag, "_valid"}, o_dump_valid, 0);
    check({tag, "_busy"}, o_dump_busy, 0);
    check({tag, "_done"}, o_dump_done, 0);
    check({tag, "_perr"}, o_parity_error, 0);
  endtask

  // One dump with randomized ready/CPU traffic; expected words come from the model window
  task automatic run_dump(input string tag, input int base, input int len,
                          input int ready_pct, input int cpu_pct, input int stall);
    logic [15:0] exp_q[$];
    logic [15:0] prev_data, rd_exp;
    logic        do_rd, do_wr, prev_hold;
    int          got, cyc, stall_left, rd_a, wr_a;
    for (int i = 0; i < len; i++) exp_q.push_back(model_mem[(base + i) % DEPTH]);
    i_dump_base = 11'(base); i_dump_len = 12'(len); i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    got = 0; cyc = 0; stall_left = stall; prev_hold = 1'b0; prev_data = '0;
    while (o_dump_done !== 1'b1 && cyc < 1000) begin
      check({tag, "_busy"}, o_dump_busy, 1);
      if (prev_hold) begin
        check({tag, "_hold_valid"}, o_dump_valid, 1);
        check({tag, "_hold_data"}, o_dump_data, prev_data);
      end
      if (stall_left > 0 && o_dump_valid === 1'b1) begin
        i_dump_ready = 1'b0; do_rd = 1'b1; do_wr = 1'b0; stall_left--;
      end else begin
        i_dump_ready = ($urandom_range(99) < ready_pct) ? 1'b1 : 1'b0;
        do_rd = ($urandom_range(99) < cpu_pct) ? 1'b1 : 1'b0;
        do_wr = (!do_rd && $urandom_range(99) < cpu_pct / 2) ? 1'b1 : 1'b0;
      end
      i_dump_start = ($urandom_range(7) == 0) ? 1'b1 : 1'b0;
      i_dump_base  = 11'($urandom);
      i_dump_len   = 12'($urandom_range(40));
      rd_a = $urandom_range(DEPTH - 1);
      wr_a = (base + len + $urandom_range(DEPTH - 1 - len)) % DEPTH;
      i_ram_rd_enable = do_rd; i_ram_wr_enable = do_wr;
      i_ram_addr = do_wr ? 11'(wr_a) : 11'(rd_a);
      i_ram_data = 16'($urandom);
      rd_exp = model_mem[rd_a];
      if (o_dump_valid === 1'b1 && i_dump_ready) begin
        check({tag, "_in_range"}, (got < len), 1);
        if (got < len) check({tag, "_word"}, o_dump_data, exp_q[got]);
        got++;
      end
      prev_hold = (o_dump_valid === 1'b1) && !i_dump_ready;
      prev_data = o_dump_data;
      if (do_wr) model_mem[wr_a] = i_ram_data;
      tick();
      cyc++;
      if (do_rd) check({tag, "_cpu_rd"}, o_ram_data, rd_exp);
    end
    i_dump_start = 1'b0; i_dump_ready = 1'b0;
    i_ram_rd_enable = 1'b0; i_ram_wr_enable = 1'b0;
    check({tag, "_done"}, o_dump_done, 1);
    check({tag, "_busy_in_done"}, o_dump_busy, 1);
    check({tag, "_no_valid_in_done"}, o_dump_valid, 0);
    check({tag, "_count"}, got, len);
    if (ready_pct >= 100 && cpu_pct == 0 && stall == 0) check({tag, "_cycles"}, cyc, 2 * len);
    tick();
    check({tag, "_done_once"}, o_dump_done, 0);
    check({tag, "_busy_fall"}, o_dump_busy, 0);
  endtask

  initial begin
    logic [15:0] e;
    int w;
    i_reset = 1'b1; i_ram_addr = '0; i_ram_data = '0; i_ram_wr_enable = 1'b0;
    i_ram_rd_enable = 1'b0; i_dump_start = 1'b0; i_dump_base = '0; i_dump_len = '0;
    i_dump_ready = 1'b0;
    #2 i_reset = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    i_reset = 1'b1;
    tick();

    for (int a = 0; a < DEPTH; a++) cpu_write(a, 16'($urandom));

    // Step 1: basic write/read, latency 1, hold when rd_enable is low
    cpu_write(5, 16'hA5A5);
    cpu_read_check("rd5", 5);
    check("rd5_const", o_ram_data, 16'hA5A5);
    tick();
    check("rd5_hold", o_ram_data, 16'hA5A5);

    // Step 2: same-cycle read/write returns the old word
    cpu_write(7, 16'h0F0F);
    e = model_mem[7];
    i_ram_addr = 11'd7; i_ram_data = 16'h1234; i_ram_wr_enable = 1'b1; i_ram_rd_enable = 1'b1;
    model_mem[7] = 16'h1234;
    tick();
    i_ram_wr_enable = 1'b0; i_ram_rd_enable = 1'b0;
    check("rdfirst_old", o_ram_data, e);
    check("rdfirst_const", o_ram_data, 16'h0F0F);
    cpu_read_check("rdfirst_new", 7);

    // Step 3: simple dump of 1,2,3
    cpu_write(2, 16'd1); cpu_write(3, 16'd2); cpu_write(4, 16'd3);
    run_dump("dump3", 2, 3, 100, 0, 0);

    // Step 4: wrap and empty dump
    run_dump("wrap", 2047, 2, 100, 0, 0);
    run_dump("len0", int'($urandom_range(DEPTH - 1)), 0, 100, 0, 0);

    // Step 5: ready held low while the CPU reads every cycle
    run_dump("stall", int'($urandom_range(DEPTH - 1)), 4, 60, 30, 5);

    // Step 6: reset mid-dump aborts asynchronously
    i_dump_base = 11'd100; i_dump_len = 12'd10; i_dump_start = 1'b1;
    tick();
    i_dump_start = 1'b0;
    w = 0;
    while (o_dump_valid !== 1'b1 && w < 20) begin tick(); w++; end
    check("abort_valid_before", o_dump_valid, 1);
    #2 i_reset = 1'b0;
    #1;
    check("abort_valid", o_dump_valid, 0);
    check("abort_busy", o_dump_busy, 0);
    check("abort_done", o_dump_done, 0);
    #2 i_reset = 1'b1;
    tick();
    tick();
    check("abort_idle_busy", o_dump_busy, 0);
    check("abort_idle_done", o_dump_done, 0);

    for (int k = 0; k < 6; k++) begin
      run_dump("rand", int'($urandom_range(DEPTH - 1)), int'($urandom_range(1, 24)),
               int'($urandom_range(30, 100)), int'($urandom_range(0, 60)), 0);
    end
    cpu_read_check("final_rd", int'($urandom_range(DEPTH - 1)));

`ifdef RAM_PARITY_EN
    check("perr_clean", o_parity_error, 0);
    dut.u_ram.par_q[9] = ~dut.u_ram.par_q[9];
    cpu_read_check("perr_rd", 9);
    check("perr_set", o_parity_error, 1);
    tick();
    tick();
    check("perr_sticky", o_parity_error, 1);
`else
    check("perr_tied", o_parity_error, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
